// File: rtl/irq_source_ctrl_pkg.sv
// Shared types, constants and helpers for the interrupt source controller.
// Holds the acknowledge FSM encoding and the vector byte composition.
package irq_source_ctrl_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned VEC_W  = 8;
  localparam int unsigned MAX_SRC = 7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_ACK_WAIT = 2'd1;
  localparam state_t ST_VEC_OUT  = 2'd2;

  // Index reported when an acknowledge finds nothing eligible.
  function automatic logic [IDX_W-1:0] spurious_idx(input int unsigned n_src);
    return IDX_W'(n_src);
  endfunction

  // IM2-style vector: table base nibble, source index, even byte address.
  function automatic logic [VEC_W-1:0] compose_vector(input logic [3:0]       base_hi,
                                                      input logic [IDX_W-1:0] sel);
    return {base_hi, sel, 1'b0};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Highest-priority (lowest index) set-bit encoder.
// Returns whether any bit is set and the index of the winning bit.
module irq_prio_enc
  import irq_source_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scan from the lowest priority upward so the lowest index wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_source_ctrl.sv
// Peripheral-side interrupt controller: edge-latched requests, nested priority,
// INTA handshake with WAIT insertion and IM2-style vector, plus a pulsed NMI.
module irq_source_ctrl
  import irq_source_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned NMI_PULSE   = 3
) (
  input  logic             Clk,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [N_SRC-1:0] MASK,
  input  logic             NMI_SRC,
  input  logic             INTA,
  input  logic             RETI,
  input  logic [7:0]       VECTOR_BASE,
  output logic             INT,
  output logic             NMI,
  output logic             WAIT,
  output logic [7:0]       VECTOR,
  output logic             VECTOR_VALID,
  output logic [N_SRC-1:0] IN_SERVICE
);

  if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_n_src
    $error("irq_source_ctrl: N_SRC out of range");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("irq_source_ctrl: WAIT_CYCLES out of range");
  end
  if (NMI_PULSE < 1 || NMI_PULSE > 15) begin : g_bad_nmi
    $error("irq_source_ctrl: NMI_PULSE out of range");
  end

  localparam logic [IDX_W-1:0] SPUR_IDX = spurious_idx(N_SRC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_SRC-1:0] irq_q, irq_d;
  logic             nmi_src_q, nmi_src_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] in_service_q, in_service_d;
  logic             int_q, int_d;
  logic             nmi_q, nmi_d;
  logic [CNT_W-1:0] nmi_cnt_q, nmi_cnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             wait_q, wait_d;
  logic             vv_q, vv_d;
  logic [7:0]       vector_q, vector_d;

  logic [N_SRC-1:0] irq_edge_c;
  logic             nmi_edge_c;
  logic [N_SRC-1:0] allow_c;
  logic [N_SRC-1:0] eligible_c;
  logic             isv_found_c;
  logic [IDX_W-1:0] isv_idx_c;
  logic             arb_found_c;
  logic [IDX_W-1:0] arb_idx_c;
  logic             grant_c;
  logic             unused_vb_lo;

  assign unused_vb_lo = ^VECTOR_BASE[3:0];

  // Current highest in-service level: gates nesting and selects the RETI clear.
  irq_prio_enc #(.N(N_SRC)) u_isv_enc (
    .req     (in_service_q),
    .found_c (isv_found_c),
    .idx_c   (isv_idx_c)
  );

  // Arbitration among eligible requests for the acknowledge.
  irq_prio_enc #(.N(N_SRC)) u_arb_enc (
    .req     (eligible_c),
    .found_c (arb_found_c),
    .idx_c   (arb_idx_c)
  );

  // Only sources strictly above the active service level may interrupt.
  always_comb begin
    allow_c = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      allow_c[i] = !isv_found_c || (IDX_W'(i) < isv_idx_c);
    end
    eligible_c = pending_q & ~MASK & allow_c;
  end

  // Acknowledge FSM: next state and registered handshake outputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    sel_d      = sel_q;
    wait_d     = 1'b0;
    vv_d       = 1'b0;
    vector_d   = 8'h00;
    grant_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (INTA) begin
          state_d    = ST_ACK_WAIT;
          wait_cnt_d = CNT_W'(WAIT_CYCLES);
          sel_d      = arb_found_c ? arb_idx_c : SPUR_IDX;
          wait_d     = 1'b1;
        end
      end
      ST_ACK_WAIT: begin
        if (wait_cnt_q == CNT_ONE) begin
          state_d    = ST_VEC_OUT;
          wait_cnt_d = '0;
          vv_d       = 1'b1;
          vector_d   = compose_vector(VECTOR_BASE[7:4], sel_q);
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_ONE;
          wait_d     = 1'b1;
        end
      end
      ST_VEC_OUT: begin
        state_d = ST_IDLE;
        grant_c = (sel_q != SPUR_IDX);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request latching, in-service bookkeeping (RETI clear before grant set).
  always_comb begin
    irq_d        = IRQ;
    irq_edge_c   = IRQ & ~irq_q;
    pending_d    = pending_q | irq_edge_c;
    in_service_d = in_service_q;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (RETI && isv_found_c && (isv_idx_c == IDX_W'(i))) begin
        in_service_d[i] = 1'b0;
      end
      if (grant_c && (sel_q == IDX_W'(i))) begin
        pending_d[i]    = 1'b0;
        in_service_d[i] = 1'b1;
      end
    end
    int_d = |eligible_c;
  end

  // NMI pulse generator; edges during an active pulse are dropped.
  always_comb begin
    nmi_src_d  = NMI_SRC;
    nmi_edge_c = NMI_SRC & ~nmi_src_q;
    nmi_cnt_d  = nmi_cnt_q;
    nmi_d      = 1'b0;
    if (nmi_cnt_q == '0) begin
      if (nmi_edge_c) begin
        nmi_cnt_d = CNT_W'(NMI_PULSE);
        nmi_d     = 1'b1;
      end
    end else begin
      nmi_cnt_d = nmi_cnt_q - CNT_ONE;
      nmi_d     = (nmi_cnt_d != '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      irq_q        <= '0;
      nmi_src_q    <= 1'b0;
      pending_q    <= '0;
      in_service_q <= '0;
      int_q        <= 1'b0;
      nmi_q        <= 1'b0;
      nmi_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      sel_q        <= '0;
      wait_q       <= 1'b0;
      vv_q         <= 1'b0;
      vector_q     <= 8'h00;
    end else begin
      irq_q        <= irq_d;
      nmi_src_q    <= nmi_src_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      int_q        <= int_d;
      nmi_q        <= nmi_d;
      nmi_cnt_q    <= nmi_cnt_d;
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      sel_q        <= sel_d;
      wait_q       <= wait_d;
      vv_q         <= vv_d;
      vector_q     <= vector_d;
    end
  end

  assign INT          = int_q;
  assign NMI          = nmi_q;
  assign WAIT         = wait_q;
  assign VECTOR       = vector_q;
  assign VECTOR_VALID = vv_q;
  assign IN_SERVICE   = in_service_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl: expected vectors go into a scoreboard
// queue, a negedge monitor pops them whenever VECTOR_VALID is presented.
module tb_irq_source_ctrl;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned WAIT_CYCLES = 2;

  logic             Clk;
  logic             RESET;
  logic [N_SRC-1:0] IRQ;
  logic [N_SRC-1:0] MASK;
  logic             NMI_SRC;
  logic             INTA;
  logic             RETI;
  logic [7:0]       VECTOR_BASE;
  logic             INT;
  logic             NMI;
  logic             WAIT;
  logic [7:0]       VECTOR;
  logic             VECTOR_VALID;
  logic [N_SRC-1:0] IN_SERVICE;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  irq_source_ctrl #(.N_SRC(N_SRC), .WAIT_CYCLES(WAIT_CYCLES), .NMI_PULSE(3)) dut (
    .Clk          (Clk),
    .RESET        (RESET),
    .IRQ          (IRQ),
    .MASK         (MASK),
    .NMI_SRC      (NMI_SRC),
    .INTA         (INTA),
    .RETI         (RETI),
    .VECTOR_BASE  (VECTOR_BASE),
    .INT          (INT),
    .NMI          (NMI),
    .WAIT         (WAIT),
    .VECTOR       (VECTOR),
    .VECTOR_VALID (VECTOR_VALID),
    .IN_SERVICE   (IN_SERVICE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Acknowledge handshake; the vector itself is checked by the monitor.
  task automatic do_ack(input logic [7:0] exp_vec);
    INTA = 1'b1;
    sb.push_back(exp_vec);
    step();
    INTA = 1'b0;
    for (int i = 0; i < int'(WAIT_CYCLES); i++) begin
      chk("wait_high", 32'(WAIT), 32'd1);
      step();
    end
    chk("wait_low_at_vec", 32'(WAIT), 32'd0);
    step();
  endtask

  task automatic do_reti();
    RETI = 1'b1;
    step();
    RETI = 1'b0;
  endtask

  always @(negedge Clk) begin
    logic [7:0] e;
    if (VECTOR_VALID === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vector: got %02h expected none", VECTOR);
      end else begin
        e = sb.pop_front();
        if (VECTOR !== e) begin
          failures++;
          $display("FAIL vector: got %02h expected %02h", VECTOR, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; IRQ = '0; MASK = '0; NMI_SRC = 1'b0;
    INTA = 1'b0; RETI = 1'b0; VECTOR_BASE = 8'hA0;
    repeat (3) step();
    RESET = 1'b0;
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_nmi", 32'(NMI), 32'd0);
    chk("rst_wait", 32'(WAIT), 32'd0);
    chk("rst_vv", 32'(VECTOR_VALID), 32'd0);
    chk("rst_vector", 32'(VECTOR), 32'h00);
    chk("rst_isv", 32'(IN_SERVICE), 32'd0);
    step();

    // Single request on source 2
    IRQ = 4'b0100;
    step();
    chk("int_latency1", 32'(INT), 32'd0);
    IRQ = 4'b0000;
    step();
    chk("int_latency2", 32'(INT), 32'd1);
    do_ack(8'hA4);
    chk("isv_src2", 32'(IN_SERVICE), 32'b0100);
    step();
    chk("int_cleared", 32'(INT), 32'd0);
    do_reti();
    chk("reti_src2", 32'(IN_SERVICE), 32'd0);

    // Two simultaneous requests, nesting blocks the lower one
    IRQ = 4'b1010;
    step();
    IRQ = 4'b0000;
    step();
    chk("int_pend13", 32'(INT), 32'd1);
    do_ack(8'hA2);
    chk("isv_src1", 32'(IN_SERVICE), 32'b0010);
    step();
    chk("nested_block_a", 32'(INT), 32'd0);
    step();
    chk("nested_block_b", 32'(INT), 32'd0);
    do_reti();
    chk("reti_src1", 32'(IN_SERVICE), 32'd0);
    chk("int_after_reti0", 32'(INT), 32'd0);
    step();
    chk("int_after_reti1", 32'(INT), 32'd1);
    do_ack(8'hA6);
    chk("isv_src3", 32'(IN_SERVICE), 32'b1000);
    do_reti();
    chk("reti_src3", 32'(IN_SERVICE), 32'd0);

    // Masking holds off INT without losing the request
    MASK = 4'b0001;
    IRQ  = 4'b0001;
    step();
    IRQ = 4'b0000;
    step();
    step();
    chk("masked_int", 32'(INT), 32'd0);
    MASK = 4'b0000;
    step();
    chk("unmasked_int", 32'(INT), 32'd1);
    do_ack(8'hA0);
    do_reti();
    chk("reti_src0", 32'(IN_SERVICE), 32'd0);
    step();
    chk("int_idle", 32'(INT), 32'd0);

    // Spurious acknowledge
    do_ack(8'hA8);
    chk("spurious_isv", 32'(IN_SERVICE), 32'd0);

    // Edge coincident with INTA is not a candidate for that acknowledge
    IRQ = 4'b0100;
    do_ack(8'hA8);
    IRQ = 4'b0000;
    chk("late_edge_isv", 32'(IN_SERVICE), 32'd0);
    step();
    chk("late_edge_int", 32'(INT), 32'd1);
    do_ack(8'hA4);
    do_reti();
    chk("reti_late", 32'(IN_SERVICE), 32'd0);

    // NMI: re-trigger during pulse ignored, later edge gives a second pulse
    NMI_SRC = 1'b1;
    step();
    chk("nmi_p1_c1", 32'(NMI), 32'd1);
    NMI_SRC = 1'b0;
    step();
    chk("nmi_p1_c2", 32'(NMI), 32'd1);
    NMI_SRC = 1'b1;
    step();
    chk("nmi_p1_c3", 32'(NMI), 32'd1);
    step();
    chk("nmi_p1_end", 32'(NMI), 32'd0);
    step();
    chk("nmi_no_retrig", 32'(NMI), 32'd0);
    NMI_SRC = 1'b0;
    step();
    NMI_SRC = 1'b1;
    step();
    chk("nmi_p2_c1", 32'(NMI), 32'd1);
    step();
    chk("nmi_p2_c2", 32'(NMI), 32'd1);
    step();
    chk("nmi_p2_c3", 32'(NMI), 32'd1);
    step();
    chk("nmi_p2_end", 32'(NMI), 32'd0);
    NMI_SRC = 1'b0;

    // Reset in the middle of an acknowledge
    IRQ = 4'b0010;
    step();
    IRQ = 4'b0000;
    step();
    chk("pre_abort_int", 32'(INT), 32'd1);
    INTA = 1'b1;
    step();
    INTA = 1'b0;
    chk("abort_wait_hi", 32'(WAIT), 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("abort_wait", 32'(WAIT), 32'd0);
    chk("abort_vv", 32'(VECTOR_VALID), 32'd0);
    chk("abort_isv", 32'(IN_SERVICE), 32'd0);
    chk("abort_int", 32'(INT), 32'd0);
    repeat (5) step();
    chk("abort_pending", 32'(INT), 32'd0);
    chk("abort_isv_late", 32'(IN_SERVICE), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
- Peripheral-side counterpart to the CPU's interrupt/wait input latches.
- Collects edge-triggered requests from up to 7 peripherals and raises INT and NMI toward the CPU.
- Answers the CPU interrupt-acknowledge strobe: inserts WAIT cycles, then drives an IM2-style vector byte.
- Tracks in-service levels for nested priority and clears them on RETI.

Parameters:
- N_SRC, 4, number of maskable sources (legal 1..7); index 0 is highest priority.
- WAIT_CYCLES, 2, WAIT-asserted cycles per acknowledge (legal 1..15).
- NMI_PULSE, 3, NMI high-time in cycles (legal 1..15).

Ports:
- Clk  in  1  single system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high block reset.
- IRQ  in  N_SRC  peripheral request levels; a rising edge latches a request.
- MASK  in  N_SRC  1 = source masked. Masking does not clear its pending bit.
- NMI_SRC  in  1  non-maskable request level; a rising edge triggers an NMI pulse.
- INTA  in  1  one-cycle CPU interrupt-acknowledge strobe.
- RETI  in  1  one-cycle end-of-service strobe from instruction decode.
- VECTOR_BASE  in  8  vector table base; only bits [7:4] are used.
- INT  out  1  maskable interrupt request to CPU.
- NMI  out  1  non-maskable request pulse to CPU.
- WAIT  out  1  wait request to CPU during acknowledge.
- VECTOR  out  8  vector byte; valid only while VECTOR_VALID=1.
- VECTOR_VALID  out  1  one-cycle strobe.
- IN_SERVICE  out  N_SRC  in-service bits (debug/status).

Behaviour:
- Reset (synchronous, while RESET=1): pending, in_service, IRQ/NMI_SRC edge registers, counters and FSM cleared; FSM=IDLE; INT=NMI=WAIT=VECTOR_VALID=0; VECTOR=8'h00. IRQ/NMI_SRC edge registers load 0, so a source held high across reset release produces an edge in the first cycle after reset.
- Edge detect: pending[i] is set in cycle t+1 when IRQ[i] is 1 at t and was 0 at t-1.
- eligible = pending & ~MASK & (higher priority than the highest-priority set IN_SERVICE bit; all priorities if none set).
- INT is registered and equals |eligible from the previous cycle, i.e. one cycle of latency.
- FSM states: IDLE, ACK_WAIT, VEC_OUT.
  - IDLE: INTA=1 -> latch sel = highest-priority eligible index, or N_SRC if none (spurious); load wait counter with WAIT_CYCLES; go to ACK_WAIT; WAIT=1 from the next cycle.
  - ACK_WAIT: decrement counter each cycle; WAIT held at 1 for exactly WAIT_CYCLES cycles; at count 1 go to VEC_OUT.
  - VEC_OUT (one cycle): WAIT=0; VECTOR_VALID=1; VECTOR = {VECTOR_BASE[7:4], sel[2:0], 1'b0}. If sel<N_SRC: clear pending[sel] and set in_service[sel]. Go to IDLE.
  - Latency: INTA at cycle t -> WAIT high for t+1..t+WAIT_CYCLES -> VECTOR_VALID at t+WAIT_CYCLES+1.
- Spurious acknowledge: vector index N_SRC; no pending or in-service change.
- INTA outside IDLE is ignored.
- RETI clears the highest-priority set in_service bit; no effect if none is set.
- Simultaneous events: arbitration uses register values from before the edge.
  - An IRQ edge in the same cycle as INTA is not a candidate for that acknowledge.
  - RETI and the VEC_OUT set in the same cycle: clear is applied first, then set.
  - An IRQ edge on a source whose pending bit is already set is absorbed (no counting).
- NMI: a NMI_SRC rising edge while NMI=0 drives NMI=1 for NMI_PULSE cycles, starting the cycle after the edge. Edges during an active pulse are ignored.
- NMI is independent of MASK, in_service and the FSM.
- RESET asserted mid-acknowledge aborts the acknowledge. The next cycle shows reset values; no vector is issued.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, ACK_WAIT, VEC_OUT);
  - spurious index constant = N_SRC;
  - vector-composition function.
- One sub-module: irq_prio_enc — combinational highest-priority (lowest index) encoder returning a valid flag and a 3-bit index. Used for both arbitration and the RETI clear.

Test Plan:
- Reset, then pulse IRQ[2] -> INT=1 two cycles after the IRQ rise. With VECTOR_BASE=8'hA0, pulse INTA -> WAIT high for 2 cycles, then VECTOR=8'hA4 with VECTOR_VALID for 1 cycle; IN_SERVICE=4'b0100; INT=0.
- IRQ[3] and IRQ[1] rise together, then INTA -> VECTOR=8'hA2. While IN_SERVICE[1]=1, INT stays 0 despite pending[3]. RETI -> INT=1 one cycle later; next INTA -> VECTOR=8'hA6.
- MASK=4'b0001 with IRQ[0] edge -> INT stays 0. Then MASK=0 -> INT=1 on the following cycle.
- INTA with nothing pending -> VECTOR=8'hA8 (spurious, index 4); IN_SERVICE unchanged.
- NMI_SRC rises, falls and rises again within 2 cycles -> exactly one NMI pulse of 3 cycles. A later rise after the pulse ends -> a second pulse.
- RESET asserted during ACK_WAIT -> WAIT=0 the next cycle; no VECTOR_VALID ever issued; pending and IN_SERVICE are 0.
